ic_fill_responder: RTL and testbench
====================================

// Module: ic_fill_responder
// PURPOSE
// - Memory-side responder for instruction-cache line fills. Accepts one miss request from the icache and issues one DRAM line read.
// - Packs the returned 32-bit words into ic_fill_t beats (4 x 16b) and returns the line to the cache as BEATS_PER_LINE=2 beats.
// - Sits between the icache miss port and the DRAM read port.
// PARAMETERS (sizes come from ic_pkg: ADDR_BITS=27, BYTES_PER_LINE=16, WORDS_PER_LINE=4)
// - BUF_DEPTH      2   beat buffer entries; must be >= BEATS_PER_LINE
// PORTS
// - clk            in   1          single clock; all logic rising-edge
// - reset          in   1          asynchronous, active-high reset
// - miss_valid     in   1          cache requests a line fill
// - miss_ready     out  1          responder accepts the request; high only in IDLE
// - miss_addr      in   ADDR_BITS  byte address of the missing fetch
// - fill_valid     out  1          beat available
// - fill_ready     in   1          cache accepts the beat
// - fill_data      out  64         ic_fill_t; [k] = bytes 2k+1:2k of the beat (little-endian)
// - fill_beat      out  1          beat index within line (byte-address bit 3)
// - fill_last      out  1          final beat of the line
// - fill_err       out  1          a memory error occurred on a word of this beat
// - mem_rd_valid   out  1          DRAM read request
// - mem_rd_ready   in   1          DRAM accepts the request
// - mem_rd_addr    out  ADDR_BITS  start byte address of the 4-word burst
// - mem_rdata_valid in  1          one word returned; cannot be stalled
// - mem_rdata      in   32         returned word
// - mem_rdata_err  in   1          error flag qualifying mem_rdata
// BEHAVIOUR
// - Reset values: miss_ready=1; fill_valid=fill_last=fill_err=fill_beat=0; fill_data=0; mem_rd_valid=0; mem_rd_addr=0.
// - FSM states and transitions:
//   - IDLE -(miss_valid)-> REQ: latches miss_addr.
//   - REQ: mem_rd_valid=1 from the cycle after acceptance. mem_rd_addr is held stable until mem_rd_ready. -> COLLECT.
//   - COLLECT: a 2-bit word counter increments on each mem_rdata_valid. The first word of each pair is held.
//     - On the second word, the {word1,word0} beat is pushed to the beat buffer.
//     - The pair's OR of mem_rdata_err is stored as that beat's fill_err.
//     - After the 4th word -> DRAIN.
//   - DRAIN -(final beat popped, fill_valid&fill_ready on fill_last)-> IDLE.
// - miss_ready is 1 only in IDLE. A new miss is taken at the earliest the cycle after the last beat handshake.
// - Beat buffer: FIFO; fill_valid=!empty. Outputs are driven from the head entry and are stable while fill_valid&!fill_ready.
//   - It cannot overflow, since at most 2 beats exist per line; push and pop in the same cycle are legal.
// - Latency: fill_valid rises the cycle after the 2nd word arrives (empty buffer). Min miss->first beat = 2 + DRAM latency + 2.
// - mem_rdata_valid outside COLLECT is ignored (protocol violation; flagged by assertion).
// - Word counter wraps 3->0 at line end. Beat index = counter[1] XOR start beat.
// - Reset mid-operation: immediate return to IDLE; the buffer, counter and outstanding state are cleared; no partial beat is emitted.
// CONFIGURATION
// - Macro IC_CRITICAL_BEAT_FIRST_EN:
//   - Defined: mem_rd_addr = {miss_addr[ADDR_BITS-1:3],3'b0}. DRAM returns words in wrap order (2,3,0,1 when bit3=1). The first fill_beat = miss_addr[3].
//   - Undefined: mem_rd_addr = {miss_addr[ADDR_BITS-1:4],4'b0}. Beats always go 0 then 1.
// STRUCTURE
// - ic_pkg additions:
//   - BEATS_PER_LINE = BYTES_PER_LINE/8
//   - WORDS_PER_BEAT = 2
//   - typedef ic_fill_state_e {IDLE,REQ,COLLECT,DRAIN}
//   - typedef struct packed ic_fill_beat_t {ic_fill_t data; logic beat, last, err;}
// - One sub-module: ic_fill_beat_buf, a BUF_DEPTH-entry FIFO of ic_fill_beat_t.
// TESTING
// 1. Reset -> miss_ready=1, fill_valid=0, mem_rd_valid=0. Hold reset 5 cycles with miss_valid=1 -> no request issued.
// 2. miss_addr=27'h0001234; DRAM returns 11111111,22222222,33333333,44444444 (err=0) -> mem_rd_addr=27'h0001230.
//    Beat0 data=64'h2222222211111111 beat=0 last=0. Beat1 data=64'h4444444433333333 beat=1 last=1. Then miss_ready=1.
// 3. mem_rd_ready low 5 cycles, fill_ready low 10 cycles during response -> request stable, both beats delivered in order, none lost.
// 4. mem_rdata_err=1 on the 3rd word only -> beat0 fill_err=0, beat1 fill_err=1.
// 5. With IC_CRITICAL_BEAT_FIRST_EN, miss_addr=27'h000123C -> mem_rd_addr=27'h0001238. First beat fill_beat=1 (words 2,3); second fill_beat=0, last=1.
// 6. Reset pulsed after 2 words returned -> IDLE next cycle, fill_valid stays 0, a following miss completes normally.

Source files
------------

// File: rtl/ic_fill_responder_pkg.sv
// Shared sizes and types for the instruction-cache line-fill responder.
package ic_fill_responder_pkg;

  localparam int unsigned ADDR_BITS      = 27;
  localparam int unsigned BYTES_PER_LINE = 16;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned BEATS_PER_LINE = BYTES_PER_LINE / 8;
  localparam int unsigned WORDS_PER_BEAT = 2;

  // [k] holds bytes 2k+1:2k of the beat (little-endian)
  typedef logic [3:0][15:0] ic_fill_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COLLECT,
    DRAIN
  } ic_fill_state_e;

  typedef struct packed {
    ic_fill_t data;
    logic     beat;
    logic     last;
    logic     err;
  } ic_fill_beat_t;

endpackage

// File: rtl/ic_fill_responder_if.sv
// Miss, fill and DRAM-read signal bundle for ic_fill_responder.
// slave = responder view, master = cache/DRAM environment view.
interface ic_fill_responder_if;
  import ic_fill_responder_pkg::*;

  logic                 miss_valid;
  logic                 miss_ready;
  logic [ADDR_BITS-1:0] miss_addr;

  logic                 fill_valid;
  logic                 fill_ready;
  ic_fill_t             fill_data;
  logic                 fill_beat;
  logic                 fill_last;
  logic                 fill_err;

  logic                 mem_rd_valid;
  logic                 mem_rd_ready;
  logic [ADDR_BITS-1:0] mem_rd_addr;
  logic                 mem_rdata_valid;
  logic [31:0]          mem_rdata;
  logic                 mem_rdata_err;

  modport slave (
    input  miss_valid, miss_addr, fill_ready, mem_rd_ready,
           mem_rdata_valid, mem_rdata, mem_rdata_err,
    output miss_ready, fill_valid, fill_data, fill_beat, fill_last, fill_err,
           mem_rd_valid, mem_rd_addr
  );

  modport master (
    output miss_valid, miss_addr, fill_ready, mem_rd_ready,
           mem_rdata_valid, mem_rdata, mem_rdata_err,
    input  miss_ready, fill_valid, fill_data, fill_beat, fill_last, fill_err,
           mem_rd_valid, mem_rd_addr
  );

endinterface

// File: rtl/ic_fill_responder_beat_buf.sv
// ic_fill_beat_buf: small FIFO of packed fill beats; head is presented
// combinationally and stays put until popped.
module ic_fill_beat_buf
  import ic_fill_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  ic_fill_beat_t din,
  input  logic          pop,
  output ic_fill_beat_t head,
  output logic          empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  ic_fill_beat_t mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage, pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Head entry and empty flag
  always_comb begin
    head  = mem_q[rd_q];
    empty = (cnt_q == '0);
  end

  // A line never produces more beats than the buffer holds
  assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (cnt_q == CW'(DEPTH))));

endmodule

// File: rtl/ic_fill_responder.sv
// ic_fill_responder: takes one icache miss, issues one 4-word DRAM burst,
// packs word pairs into 64-bit beats and returns them through a beat FIFO.
// Optional macro IC_CRITICAL_BEAT_FIRST_EN: burst starts at the missed
// beat (8-byte aligned) so the critical beat is returned first.
module ic_fill_responder
  import ic_fill_responder_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic               clk,
  input logic               reset,
  ic_fill_responder_if.slave bus
);

  ic_fill_state_e       state_q;
  ic_fill_state_e       state_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [1:0]           cnt_q;
  logic [31:0]          word0_q;
  logic                 err0_q;
  logic                 start_beat;
  logic                 take;
  logic                 word_in;
  logic                 push;
  logic                 pop;
  logic                 empty;
  ic_fill_beat_t        push_beat;
  ic_fill_beat_t        head;

`ifdef IC_CRITICAL_BEAT_FIRST_EN
  logic [2:0] unused_addr_bits;
  assign unused_addr_bits = addr_q[2:0];
  assign start_beat       = addr_q[3];
  assign bus.mem_rd_addr  = {addr_q[ADDR_BITS-1:3], 3'b0};
`else
  logic [3:0] unused_addr_bits;
  assign unused_addr_bits = addr_q[3:0];
  assign start_beat       = 1'b0;
  assign bus.mem_rd_addr  = {addr_q[ADDR_BITS-1:4], 4'b0};
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Miss address latch, word counter and held first word of each pair
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      word0_q <= '0;
      err0_q  <= 1'b0;
    end else begin
      if (take) addr_q <= bus.miss_addr;
      if (word_in) begin
        cnt_q <= cnt_q + 2'd1;
        if (!cnt_q[0]) begin
          word0_q <= bus.mem_rdata;
          err0_q  <= bus.mem_rdata_err;
        end
      end
    end
  end

  // Next state, handshakes and beat assembly
  always_comb begin
    state_d          = state_q;
    bus.miss_ready   = (state_q == IDLE);
    bus.mem_rd_valid = (state_q == REQ);
    take             = (state_q == IDLE) && bus.miss_valid;
    word_in          = (state_q == COLLECT) && bus.mem_rdata_valid;
    push             = word_in && cnt_q[0];
    pop              = !empty && bus.fill_ready;
    push_beat.data   = {bus.mem_rdata, word0_q};
    push_beat.beat   = cnt_q[1] ^ start_beat;
    push_beat.last   = (cnt_q == 2'd3);
    push_beat.err    = err0_q | bus.mem_rdata_err;
    case (state_q)
      IDLE:    if (bus.miss_valid) state_d = REQ;
      REQ:     if (bus.mem_rd_ready) state_d = COLLECT;
      COLLECT: if (word_in && (cnt_q == 2'd3)) state_d = DRAIN;
      DRAIN:   if (pop && head.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fill port driven from the FIFO head; zeros while nothing is pending
  always_comb begin
    bus.fill_valid = !empty;
    bus.fill_data  = empty ? '0 : head.data;
    bus.fill_beat  = !empty && head.beat;
    bus.fill_last  = !empty && head.last;
    bus.fill_err   = !empty && head.err;
  end

  ic_fill_beat_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_beat),
    .pop   (pop),
    .head  (head),
    .empty (empty)
  );

  // DRAM data cannot be stalled, so a word outside a burst is a protocol error
  assert property (@(posedge clk) disable iff (reset)
    bus.mem_rdata_valid |-> (state_q == COLLECT));

endmodule

// File: tb/tb_ic_fill_responder.sv
// Directed bench for ic_fill_responder with a line-level reference model.
module tb_ic_fill_responder;
  import ic_fill_responder_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic        beat;
    logic        last;
    logic        err;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  int unsigned errors = 0;
  int unsigned checks = 0;

  ic_fill_responder_if bus();

  ic_fill_responder #(.BUF_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst start the DRAM must be asked for, derived from the miss address
  function automatic logic [ADDR_BITS-1:0] line_start(input logic [ADDR_BITS-1:0] a);
`ifdef IC_CRITICAL_BEAT_FIRST_EN
    return a & ~(ADDR_BITS'(7));
`else
    return a & ~(ADDR_BITS'(15));
`endif
  endfunction

  // Reference model state
  beat_t                exp_q[$];
  beat_t                obs_q[$];
  logic                 m_busy = 1'b0;
  logic                 m_req  = 1'b0;
  logic [ADDR_BITS-1:0] m_addr = '0;
  int unsigned          m_n    = 0;
  logic [31:0]          m_w0   = '0;
  logic                 m_e0   = 1'b0;

  // Per-cycle compare against the model, then advance the model by what
  // the next rising edge will see
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_miss_ready",   bus.miss_ready, 1);
        check("rst_fill_valid",   bus.fill_valid, 0);
        check("rst_mem_rd_valid", bus.mem_rd_valid, 0);
        check("rst_mem_rd_addr",  bus.mem_rd_addr, 0);
        check("rst_fill_data",    bus.fill_data, 0);
        exp_q.delete();
        m_busy = 1'b0;
        m_req  = 1'b0;
        m_n    = 0;
      end else begin
        check("miss_ready",   bus.miss_ready, !m_busy);
        check("mem_rd_valid", bus.mem_rd_valid, m_req);
        if (m_req) check("mem_rd_addr", bus.mem_rd_addr, line_start(m_addr));
        check("fill_valid", bus.fill_valid, exp_q.size() != 0);
        if (bus.fill_valid && exp_q.size() != 0) begin
          check("fill_data", bus.fill_data, exp_q[0].data);
          check("fill_beat", bus.fill_beat, exp_q[0].beat);
          check("fill_last", bus.fill_last, exp_q[0].last);
          check("fill_err",  bus.fill_err,  exp_q[0].err);
        end
        if (bus.miss_valid && bus.miss_ready) begin
          m_busy = 1'b1;
          m_req  = 1'b1;
          m_addr = bus.miss_addr;
          m_n    = 0;
        end
        if (m_req && bus.mem_rd_valid && bus.mem_rd_ready) m_req = 1'b0;
        if (bus.mem_rdata_valid) begin
          if (m_n % 2 == 0) begin
            m_w0 = bus.mem_rdata;
            m_e0 = bus.mem_rdata_err;
          end else begin
            beat_t b;
            int unsigned pair;
            pair   = m_n / 2;
            b.data = {bus.mem_rdata, m_w0};
            b.beat = 1'(((line_start(m_addr) / 8) + pair) % 2);
            b.last = (pair == BEATS_PER_LINE - 1);
            b.err  = m_e0 | bus.mem_rdata_err;
            exp_q.push_back(b);
          end
          m_n++;
        end
        if (bus.fill_valid && bus.fill_ready && exp_q.size() != 0) begin
          beat_t o;
          o.data = bus.fill_data;
          o.beat = bus.fill_beat;
          o.last = bus.fill_last;
          o.err  = bus.fill_err;
          obs_q.push_back(o);
          if (exp_q[0].last) m_busy = 1'b0;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_miss(input logic [ADDR_BITS-1:0] a);
    int unsigned n = 0;
    bus.miss_addr  = a;
    bus.miss_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.miss_ready && n < 50);
    check("miss_accepted", bus.miss_ready, 1);
    @(posedge clk); #1;
    bus.miss_valid = 1'b0;
  endtask

  task automatic mem_accept(input int unsigned delay, output logic [ADDR_BITS-1:0] addr);
    int unsigned n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_rd_valid && n < 50);
    check("mem_rd_issued", bus.mem_rd_valid, 1);
    addr = bus.mem_rd_addr;
    @(posedge clk); #1;
    repeat (delay) begin @(posedge clk); #1; end
    bus.mem_rd_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_rd_ready = 1'b0;
  endtask

  task automatic send_words(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3,
                            input logic [3:0] err, input int unsigned nwords,
                            input int unsigned gap);
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < int'(nwords); i++) begin
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = w[i];
      bus.mem_rdata_err   = err[i];
      @(posedge clk); #1;
      bus.mem_rdata_valid = 1'b0;
      bus.mem_rdata_err   = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    do begin @(negedge clk); n++; end while (!(bus.miss_ready && !bus.fill_valid) && n < 100);
    check("back_to_idle", bus.miss_ready && !bus.fill_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_line(input string name, input beat_t e0, input beat_t e1);
    check({name, "_beats"}, obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check({name, "_b0_data"}, obs_q[0].data, e0.data);
      check({name, "_b0_beat"}, obs_q[0].beat, e0.beat);
      check({name, "_b0_last"}, obs_q[0].last, e0.last);
      check({name, "_b0_err"},  obs_q[0].err,  e0.err);
      check({name, "_b1_data"}, obs_q[1].data, e1.data);
      check({name, "_b1_beat"}, obs_q[1].beat, e1.beat);
      check({name, "_b1_last"}, obs_q[1].last, e1.last);
      check({name, "_b1_err"},  obs_q[1].err,  e1.err);
    end
    obs_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [ADDR_BITS-1:0] ra;
    beat_t lo, hi;
    reset               = 1'b1;
    bus.miss_valid      = 1'b1;
    bus.miss_addr       = 27'h0001234;
    bus.fill_ready      = 1'b1;
    bus.mem_rd_ready    = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
    bus.mem_rdata_err   = 1'b0;

    // 1: reset held 5 cycles with a pending miss; nothing issued afterwards
    repeat (5) @(posedge clk);
    #1;
    reset          = 1'b0;
    bus.miss_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("t1_miss_ready",   bus.miss_ready, 1);
    check("t1_mem_rd_valid", bus.mem_rd_valid, 0);
    @(posedge clk); #1;

    // 2: basic line fill, no stalls
    do_miss(27'h0001234);
    mem_accept(0, ra);
    check("t2_rd_addr", ra, 27'h0001230);
    send_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4'b0000, 4, 0);
    wait_idle();
    lo = '{64'h2222222211111111, 1'b0, 1'b0, 1'b0};
    hi = '{64'h4444444433333333, 1'b1, 1'b1, 1'b0};
    check_line("t2", lo, hi);

    // 3: DRAM request stalled 5 cycles, fill port stalled during response
    bus.fill_ready = 1'b0;
    do_miss(27'h0002A50);
    mem_accept(5, ra);
    check("t3_rd_addr", ra, 27'h0002A50);
    send_words(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, 4'b0000, 4, 1);
    repeat (10) begin @(posedge clk); #1; end
    bus.fill_ready = 1'b1;
    wait_idle();
    lo = '{64'hB1B1B1B1A0A0A0A0, 1'b0, 1'b0, 1'b0};
    hi = '{64'hD3D3D3D3C2C2C2C2, 1'b1, 1'b1, 1'b0};
    check_line("t3", lo, hi);

    // 4: error on the third word only marks the second beat
    do_miss(27'h0004000);
    mem_accept(1, ra);
    check("t4_rd_addr", ra, 27'h0004000);
    send_words(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D, 4'b0100, 4, 0);
    wait_idle();
    lo = '{64'h01234567DEADBEEF, 1'b0, 1'b0, 1'b0};
    hi = '{64'hCAFEF00D89ABCDEF, 1'b1, 1'b1, 1'b1};
    check_line("t4", lo, hi);

    // 5: miss in the upper half of the line
    do_miss(27'h000123C);
    mem_accept(0, ra);
`ifdef IC_CRITICAL_BEAT_FIRST_EN
    check("t5_rd_addr", ra, 27'h0001238);
    send_words(32'h33333333, 32'h44444444, 32'h11111111, 32'h22222222, 4'b0000, 4, 0);
    wait_idle();
    lo = '{64'h4444444433333333, 1'b1, 1'b0, 1'b0};
    hi = '{64'h2222222211111111, 1'b0, 1'b1, 1'b0};
`else
    check("t5_rd_addr", ra, 27'h0001230);
    send_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4'b0000, 4, 0);
    wait_idle();
    lo = '{64'h2222222211111111, 1'b0, 1'b0, 1'b0};
    hi = '{64'h4444444433333333, 1'b1, 1'b1, 1'b0};
`endif
    check_line("t5", lo, hi);

    // 6: reset after two words; no beat escapes, next miss completes
    do_miss(27'h0000100);
    mem_accept(0, ra);
    send_words(32'h55555555, 32'h66666666, 32'h0, 32'h0, 4'b0000, 2, 0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_fill_valid", bus.fill_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_idle_miss_ready", bus.miss_ready, 1);
    check("t6_idle_fill_valid", bus.fill_valid, 0);
    check("t6_no_beats", obs_q.size(), 0);
    @(posedge clk); #1;
    do_miss(27'h0000200);
    mem_accept(2, ra);
    check("t6_rd_addr", ra, 27'h0000200);
    send_words(32'h77777777, 32'h88888888, 32'h99999999, 32'hAAAAAAAA, 4'b1000, 4, 0);
    wait_idle();
    lo = '{64'h8888888877777777, 1'b0, 1'b0, 1'b0};
    hi = '{64'hAAAAAAAA99999999, 1'b1, 1'b1, 1'b1};
    check_line("t6", lo, hi);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
